// File: rtl/mc_controller_if.sv
// Control bundle between the multicycle MIPS control FSM and its datapath.
// The controller drives every strobe and select; the datapath supplies the
// opcode from the instruction register and the ALU zero flag.
interface mc_controller_if;
    logic [5:0] op;
    logic       zero;
    logic       pcen;
    logic       irwrite;
    logic       memwrite;
    logic       regwrite;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       zext;
    logic [1:0] aluop;
    logic [1:0] pcsrc;
    logic       retire;
    logic       illegal_op;
    logic       halted;
    logic [3:0] state;

    // Controller side.
    modport master (
        input  op, zero,
        output pcen, irwrite, memwrite, regwrite, iord, memtoreg, regdst,
               alusrca, alusrcb, zext, aluop, pcsrc, retire, illegal_op,
               halted, state
    );

    // Datapath side.
    modport slave (
        output op, zero,
        input  pcen, irwrite, memwrite, regwrite, iord, memtoreg, regdst,
               alusrca, alusrcb, zext, aluop, pcsrc, retire, illegal_op,
               halted, state
    );
endinterface

// File: rtl/mc_controller.sv
// Main control FSM of the multicycle MIPS datapath. Each instruction takes
// 2-5 cycles; the per-state control word is registered alongside the state,
// so every output except pcen, retire and illegal_op is a flop output.
// pcen follows the ALU zero flag during BEQEX, and the DECODE-time illegal
// opcode indication depends on op, which only becomes valid in DECODE.
module mc_controller #(
    parameter bit ILLEGAL_TRAP = 1'b0
) (
    input  logic            clk,
    input  logic            reset,
    mc_controller_if.master bus
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ORIEX   = 4'd10,
        S_IWB     = 4'd11,
        S_JEX     = 4'd12,
        S_HALT    = 4'd15
    } state_t;

    // Control word associated with one state.
    typedef struct packed {
        logic       pcwrite;
        logic       branch;
        logic       irwrite;
        logic       memwrite;
        logic       regwrite;
        logic       iord;
        logic       memtoreg;
        logic       regdst;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic       zext;
        logic [1:0] aluop;
        logic [1:0] pcsrc;
        logic       retire;
        logic       halted;
    } ctrl_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // Control word for a state; anything not set here stays 0.
    function automatic ctrl_t state_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.irwrite = 1'b1;
                c.pcwrite = 1'b1;
                c.alusrcb = 2'b01;
            end
            S_DECODE: begin
                c.alusrcb = 2'b11;
            end
            S_MEMADR: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
            end
            S_MEMRD: begin
                c.iord = 1'b1;
            end
            S_MEMWB: begin
                c.memtoreg = 1'b1;
                c.regwrite = 1'b1;
                c.retire   = 1'b1;
            end
            S_MEMWR: begin
                c.iord     = 1'b1;
                c.memwrite = 1'b1;
                c.retire   = 1'b1;
            end
            S_RTYPEEX: begin
                c.alusrca = 1'b1;
                c.aluop   = 2'b10;
            end
            S_RTYPEWB: begin
                c.regdst   = 1'b1;
                c.regwrite = 1'b1;
                c.retire   = 1'b1;
            end
            S_BEQEX: begin
                c.alusrca = 1'b1;
                c.aluop   = 2'b01;
                c.pcsrc   = 2'b01;
                c.branch  = 1'b1;
                c.retire  = 1'b1;
            end
            S_ADDIEX: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
            end
            S_ORIEX: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
                c.zext    = 1'b1;
                c.aluop   = 2'b11;
            end
            S_IWB: begin
                c.regwrite = 1'b1;
                c.retire   = 1'b1;
            end
            S_JEX: begin
                c.pcsrc   = 2'b10;
                c.pcwrite = 1'b1;
                c.retire  = 1'b1;
            end
            S_HALT: begin
                c.halted = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    state_t r_state;
    ctrl_t  r_ctrl;
    state_t w_next;
    logic   w_op_known;
    logic   w_illegal;
    logic   w_run;

    // Next-state selection and recognition of the opcode in DECODE.
    always_comb begin
        // NOTE: every variable gets a default up front so no path through the case infers a latch.
        w_next     = S_FETCH;
        w_op_known = 1'b1;
        case (r_state)
            S_FETCH:   w_next = S_DECODE;
            S_DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYPE:     w_next = S_RTYPEEX;
                    OP_BEQ:       w_next = S_BEQEX;
                    OP_ADDI:      w_next = S_ADDIEX;
                    OP_ORI:       w_next = S_ORIEX;
                    OP_J:         w_next = S_JEX;
                    default: begin
                        w_op_known = 1'b0;
                        w_next     = ILLEGAL_TRAP ? S_HALT : S_FETCH;
                    end
                endcase
            end
            S_MEMADR:  w_next = (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   w_next = S_MEMWB;
            S_RTYPEEX: w_next = S_RTYPEWB;
            S_ADDIEX:  w_next = S_IWB;
            S_ORIEX:   w_next = S_IWB;
            S_HALT:    w_next = S_HALT;
            default:   w_next = S_FETCH;
        endcase
        w_illegal = (r_state == S_DECODE) && !w_op_known;
    end

    // State register with the control word for the state being entered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_ctrl  <= state_ctrl(S_FETCH);
        end else begin
            // NOTE: non-blocking so state and control word both update from pre-edge values.
            r_state <= w_next;
            r_ctrl  <= state_ctrl(w_next);
        end
    end

    // Write strobes and pulses are held low for as long as reset is high.
    assign w_run = ~reset;

    assign bus.pcen       = w_run & (r_ctrl.pcwrite | (r_ctrl.branch & bus.zero));
    assign bus.irwrite    = w_run & r_ctrl.irwrite;
    assign bus.memwrite   = w_run & r_ctrl.memwrite;
    assign bus.regwrite   = w_run & r_ctrl.regwrite;
    assign bus.retire     = w_run & (r_ctrl.retire | (w_illegal & !ILLEGAL_TRAP));
    assign bus.illegal_op = w_run & w_illegal;
    assign bus.iord       = r_ctrl.iord;
    assign bus.memtoreg   = r_ctrl.memtoreg;
    assign bus.regdst     = r_ctrl.regdst;
    assign bus.alusrca    = r_ctrl.alusrca;
    assign bus.alusrcb    = r_ctrl.alusrcb;
    assign bus.zext       = r_ctrl.zext;
    assign bus.aluop      = r_ctrl.aluop;
    assign bus.pcsrc      = r_ctrl.pcsrc;
    assign bus.halted     = r_ctrl.halted;
    assign bus.state      = r_state;

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: walks every instruction class through the
// FSM, comparing the full control vector each cycle against hand-written
// expectations. Two instances run in lockstep, one without and one with the
// illegal-opcode trap.
module tb_mc_controller;

    logic       clk;
    logic       reset;
    logic [5:0] op;
    logic       zero;

    int n_checks;
    int n_errors;

    mc_controller_if bus0 ();
    mc_controller_if bus1 ();

    assign bus0.op   = op;
    assign bus0.zero = zero;
    assign bus1.op   = op;
    assign bus1.zero = zero;

    mc_controller #(.ILLEGAL_TRAP(1'b0)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    mc_controller #(.ILLEGAL_TRAP(1'b1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed control vector, same field order as mk() below.
    logic [21:0] obs0;
    logic [21:0] obs1;
    assign obs0 = {bus0.state, bus0.pcen, bus0.irwrite, bus0.memwrite, bus0.regwrite,
                   bus0.iord, bus0.memtoreg, bus0.regdst, bus0.alusrca, bus0.alusrcb,
                   bus0.zext, bus0.aluop, bus0.pcsrc, bus0.retire, bus0.illegal_op,
                   bus0.halted};
    assign obs1 = {bus1.state, bus1.pcen, bus1.irwrite, bus1.memwrite, bus1.regwrite,
                   bus1.iord, bus1.memtoreg, bus1.regdst, bus1.alusrca, bus1.alusrcb,
                   bus1.zext, bus1.aluop, bus1.pcsrc, bus1.retire, bus1.illegal_op,
                   bus1.halted};

    function automatic logic [21:0] mk(
        input logic [3:0] st,
        input logic       pcen, irw, memw, regw, iord, m2r, rdst, asa,
        input logic [1:0] asb,
        input logic       zx,
        input logic [1:0] aop, psrc,
        input logic       ret, ill, hlt
    );
        return {st, pcen, irw, memw, regw, iord, m2r, rdst, asa, asb, zx, aop, psrc,
                ret, ill, hlt};
    endfunction

    //                                 st  pc ir mw rw io mr rd sa  asb zx aop  psrc rt il hl
    localparam logic [21:0] V_RST    = mk(0,  0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 0, 2'b00, 2'b00, 0, 0, 0);
    localparam logic [21:0] V_FETCH  = mk(0,  1, 1, 0, 0, 0, 0, 0, 0, 2'b01, 0, 2'b00, 2'b00, 0, 0, 0);
    localparam logic [21:0] V_DECODE = mk(1,  0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 0, 2'b00, 2'b00, 0, 0, 0);
    localparam logic [21:0] V_DECNOP = mk(1,  0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 0, 2'b00, 2'b00, 1, 1, 0);
    localparam logic [21:0] V_DECTRP = mk(1,  0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 0, 2'b00, 2'b00, 0, 1, 0);
    localparam logic [21:0] V_MEMADR = mk(2,  0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 0, 2'b00, 2'b00, 0, 0, 0);
    localparam logic [21:0] V_MEMRD  = mk(3,  0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 0, 0);
    localparam logic [21:0] V_MEMWB  = mk(4,  0, 0, 0, 1, 0, 1, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1, 0, 0);
    localparam logic [21:0] V_MEMWR  = mk(5,  0, 0, 1, 0, 1, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1, 0, 0);
    localparam logic [21:0] V_RTEX   = mk(6,  0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 2'b10, 2'b00, 0, 0, 0);
    localparam logic [21:0] V_RTWB   = mk(7,  0, 0, 0, 1, 0, 0, 1, 0, 2'b00, 0, 2'b00, 2'b00, 1, 0, 0);
    localparam logic [21:0] V_BEQ_T  = mk(8,  1, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 2'b01, 2'b01, 1, 0, 0);
    localparam logic [21:0] V_BEQ_N  = mk(8,  0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 2'b01, 2'b01, 1, 0, 0);
    localparam logic [21:0] V_ADDIEX = mk(9,  0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 0, 2'b00, 2'b00, 0, 0, 0);
    localparam logic [21:0] V_ORIEX  = mk(10, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 1, 2'b11, 2'b00, 0, 0, 0);
    localparam logic [21:0] V_IWB    = mk(11, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1, 0, 0);
    localparam logic [21:0] V_JEX    = mk(12, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b10, 1, 0, 0);
    localparam logic [21:0] V_HALT   = mk(15, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 0, 1);

    task automatic check(input string tag, input logic [21:0] got, input logic [21:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%b exp=%b (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Entered just after a rising edge; checks mid-cycle, returns after the next edge.
    task automatic step(input string tag, input logic [21:0] exp);
        @(negedge clk);
        check(tag, obs0, exp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b1;
        op       = 6'b100011;
        zero     = 1'b0;

        // Reset state: FETCH selects with strobes held low.
        #12;
        check("reset_state", obs0, V_RST);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // lw: 5 cycles, first cycle after release is a live FETCH.
        step("lw_fetch",  V_FETCH);
        step("lw_decode", V_DECODE);
        step("lw_memadr", V_MEMADR);
        step("lw_memrd",  V_MEMRD);
        step("lw_memwb",  V_MEMWB);

        // Reset asserted in the middle of MEMRD of a second lw.
        step("lw2_fetch",  V_FETCH);
        step("lw2_decode", V_DECODE);
        step("lw2_memadr", V_MEMADR);
        #2;
        reset = 1'b1;
        #1;
        check("rst_async", obs0, V_RST);
        @(posedge clk);
        #1;
        check("rst_hold", obs0, V_RST);
        reset = 1'b0;

        // sw
        op = 6'b101011;
        step("sw_fetch",  V_FETCH);
        step("sw_decode", V_DECODE);
        step("sw_memadr", V_MEMADR);
        step("sw_memwr",  V_MEMWR);

        // R-type
        op = 6'b000000;
        step("rt_fetch",  V_FETCH);
        step("rt_decode", V_DECODE);
        step("rt_ex",     V_RTEX);
        step("rt_wb",     V_RTWB);

        // addi
        op = 6'b001000;
        step("addi_fetch",  V_FETCH);
        step("addi_decode", V_DECODE);
        step("addi_ex",     V_ADDIEX);
        step("addi_wb",     V_IWB);

        // ori
        op = 6'b001101;
        step("ori_fetch",  V_FETCH);
        step("ori_decode", V_DECODE);
        step("ori_ex",     V_ORIEX);
        step("ori_wb",     V_IWB);

        // beq taken, then not taken
        op   = 6'b000100;
        zero = 1'b1;
        step("beq_t_fetch",  V_FETCH);
        step("beq_t_decode", V_DECODE);
        step("beq_t_ex",     V_BEQ_T);
        zero = 1'b0;
        step("beq_n_fetch",  V_FETCH);
        step("beq_n_decode", V_DECODE);
        step("beq_n_ex",     V_BEQ_N);

        // beq where zero rises mid-BEQEX: pcen must follow immediately.
        step("beq_l_fetch",  V_FETCH);
        step("beq_l_decode", V_DECODE);
        @(negedge clk);
        check("beq_l_ex_low", obs0, V_BEQ_N);
        zero = 1'b1;
        #1;
        check("beq_l_ex_high", obs0, V_BEQ_T);
        @(posedge clk);
        #1;
        zero = 1'b0;

        // j
        op = 6'b000010;
        step("j_fetch",  V_FETCH);
        step("j_decode", V_DECODE);
        step("j_ex",     V_JEX);

        // Illegal opcode: NOP on dut0, trap on dut1.
        op = 6'b111111;
        step("ill_fetch", V_FETCH);
        @(negedge clk);
        check("ill_decode_nop",  obs0, V_DECNOP);
        check("ill_decode_trap", obs1, V_DECTRP);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("ill_nop_refetch", obs0, V_FETCH);
        check("ill_trap_halt",   obs1, V_HALT);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            check($sformatf("halt_hold_%0d", i), obs1, V_HALT);
        end

        // Reset releases the trapped instance into a fresh FETCH.
        #2;
        reset = 1'b1;
        #1;
        check("trap_rst_async", obs1, V_RST);
        @(posedge clk);
        #1;
        reset = 1'b0;
        op    = 6'b100011;
        @(negedge clk);
        check("trap_fetch", obs1, V_FETCH);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("trap_decode", obs1, V_DECODE);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
